// File: rtl/legv8_pkg.sv
// legv8_pkg: shared LEGv8 constants and helpers for the fetch stage
package legv8_pkg;
  localparam int PC_WIDTH_DEF = 10;
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction-memory bus plus IF/ID outputs of the fetch stage
interface instruction_fetch_if import legv8_pkg::*; #(parameter int PC_WIDTH = PC_WIDTH_DEF);
  logic [PC_WIDTH-1:0] pc_out;
  logic [31:0]         instr_in;
  logic [PC_WIDTH-1:0] if_id_pc;
  logic [31:0]         if_id_instr;
  logic                if_id_valid;
  modport master (output pc_out, if_id_pc, if_id_instr, if_id_valid, input instr_in);
  modport slave  (input pc_out, if_id_pc, if_id_instr, if_id_valid, output instr_in);
endinterface

// File: rtl/instruction_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with kill (flush/redirect) and stall hold
module if_id_reg import legv8_pkg::*; #(parameter int PC_WIDTH = PC_WIDTH_DEF) (
  input  logic                clk,
  input  logic                reset,
  input  logic                kill,
  input  logic                stall,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic [31:0]         instr_in,
  output logic [PC_WIDTH-1:0] if_id_pc,
  output logic [31:0]         if_id_instr,
  output logic                if_id_valid
);
  // kill inserts a bubble, stall holds, otherwise capture the fetched word
  always_ff @(posedge clk or posedge reset)
    if (reset || kill) begin
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_pc    <= pc_in;
      if_id_instr <= instr_in;
      if_id_valid <= 1'b1;
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and IF/ID capture; FETCH_PERF_CNT_EN adds fetch/stall counters
module instruction_fetch import legv8_pkg::*; #(
  parameter int                  PC_WIDTH = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  instruction_fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [31:0]         stall_count
`endif
);
  logic [PC_WIDTH-1:0] pc;
  logic kill;
  assign kill = flush | branch_taken;
  assign bus.pc_out = pc;
  // redirect wins over stall; targets are forced word-aligned; sequential wraps naturally
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= RESET_PC;
    else pc <= branch_taken ? {branch_target[PC_WIDTH-1:2], 2'b00} : stall ? pc : pc + PC_WIDTH'(4);
  if_id_reg #(.PC_WIDTH(PC_WIDTH)) u_if_id (
    .clk(clk),
    .reset(reset),
    .kill(kill),
    .stall(stall),
    .pc_in(pc),
    .instr_in(bus.instr_in),
    .if_id_pc(bus.if_id_pc),
    .if_id_instr(bus.if_id_instr),
    .if_id_valid(bus.if_id_valid)
  );
`ifdef FETCH_PERF_CNT_EN
  // count real captures and PC-holding stalls, saturating
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (!kill && !stall) fetch_count <= sat_inc(fetch_count);
      if (stall && !branch_taken) stall_count <= sat_inc(stall_count);
    end
`endif
endmodule
